// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM encoding and calibration helpers for the UART auto-baud controller
package uart_pkg;
    localparam int unsigned CLK_FRQ_DEF      = 100000000;
    localparam int unsigned DEFAULT_BAUD_DEF = 9600;
    localparam logic [7:0]  CAL_CHAR         = 8'h55;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        WAIT_EDGE,
        MEASURE,
        DONE,
        ERROR
    } cal_state_t;

    // Falling edges seen on an 8N1 frame of c, starting from an idle-high line
    function automatic int unsigned frame_falls(input logic [7:0] c);
        logic [9:0] f;
        logic p;
        int unsigned n;
        f = {1'b1, c, 1'b0};
        p = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (p && !f[i]) n++;
            p = f[i];
        end
        return n;
    endfunction

    localparam int unsigned CAL_EDGES = frame_falls(CAL_CHAR);
endpackage

// File: rtl/uart_autobaud_ctrl_if.sv
// uart_autobaud_ctrl_if: line input, calibration request and baud result/status bundle
interface uart_autobaud_ctrl_if;
    logic        rx;
    logic        cal_start;
    logic [31:0] baud_tick_count;
    logic        tick_update;
    logic        busy;
    logic        locked;
    logic        cal_err;

    modport master (
        output rx, cal_start,
        input  baud_tick_count, tick_update, busy, locked, cal_err
    );

    modport slave (
        input  rx, cal_start,
        output baud_tick_count, tick_update, busy, locked, cal_err
    );
endinterface

// File: rtl/uart_rx_edge_det.sv
// uart_rx_edge_det: rx synchroniser, optional majority glitch filter (UART_AUTOBAUD_GLITCH_FILTER_EN) and falling-edge detector
module uart_rx_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic line,
    output logic fall
);
    logic [1:0] sync;
    logic       prev;

    // Two-flop synchroniser, reset to the idle-high level
    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx};
    end

`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
    logic [1:0] hist;

    // Two-deep history so a lone one-cycle sample is outvoted by its neighbours
    always_ff @(posedge clk) begin
        if (rst) hist <= 2'b11;
        else     hist <= {hist[0], sync[1]};
    end

    assign line = (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
`else
    assign line = sync[1];
`endif

    // Previous line level for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= line;
    end

    assign fall = prev & ~line;
endmodule

// File: rtl/uart_autobaud_ctrl.sv
// uart_autobaud_ctrl: measures a 0x55 calibration character and loads the receiver's clocks-per-bit; see UART_AUTOBAUD_GLITCH_FILTER_EN in uart_rx_edge_det
module uart_autobaud_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FRQ      = CLK_FRQ_DEF,
    parameter int unsigned DEFAULT_BAUD = DEFAULT_BAUD_DEF,
    parameter int unsigned MIN_TICKS    = 16,
    parameter int unsigned MAX_TICKS    = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_autobaud_ctrl_if.slave   bus
);
    localparam logic [31:0] RST_TICKS = 32'(CLK_FRQ / DEFAULT_BAUD);
    localparam logic [31:0] SPAN_MAX  = 32'(8 * MAX_TICKS);
    localparam logic [2:0]  LAST_EDGE = 3'(CAL_EDGES - 2);

    cal_state_t  state;
    logic [31:0] idle_cnt;
    logic [31:0] span;
    logic [2:0]  edge_cnt;
    logic [31:0] baud;
    logic        tick_update;
    logic        busy;
    logic        locked;
    logic        cal_err;
    logic        line;
    logic        fall;
    logic [31:0] result;
    logic        in_range;

    uart_rx_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .rx   (bus.rx),
        .line (line),
        .fall (fall)
    );

    // Span covers 8 bit times between the first and last falling edge; round to nearest
    assign result   = (span + 32'd4) >> 3;
    assign in_range = (result >= MIN_TICKS) && (result <= MAX_TICKS);

    // Calibration FSM with registered status outputs; cal_start restarts from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idle_cnt    <= '0;
            span        <= '0;
            edge_cnt    <= '0;
            baud        <= RST_TICKS;
            tick_update <= 1'b0;
            busy        <= 1'b0;
            locked      <= 1'b0;
            cal_err     <= 1'b0;
        end else begin
            tick_update <= 1'b0;
            if (bus.cal_start) begin
                state    <= WAIT_IDLE;
                idle_cnt <= '0;
                busy     <= 1'b1;
                locked   <= 1'b0;
                cal_err  <= 1'b0;
            end else begin
                case (state)
                    WAIT_IDLE: begin
                        if (!line)                       idle_cnt <= '0;
                        else if (idle_cnt == MAX_TICKS - 1) state <= WAIT_EDGE;
                        else                             idle_cnt <= idle_cnt + 1;
                    end
                    WAIT_EDGE: begin
                        if (fall) begin
                            span     <= '0;
                            edge_cnt <= '0;
                            state    <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        span <= span + 1;
                        if (fall) edge_cnt <= edge_cnt + 3'd1;
                        if (fall && edge_cnt == LAST_EDGE) begin
                            state <= DONE;
                        end else if (span == SPAN_MAX - 1) begin
                            state <= ERROR;
                            busy  <= 1'b0;
                        end
                    end
                    DONE: begin
                        busy <= 1'b0;
                        if (in_range) begin
                            baud        <= result;
                            tick_update <= 1'b1;
                            locked      <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            state <= ERROR;
                        end
                    end
                    ERROR: begin
                        cal_err <= 1'b1;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.baud_tick_count = baud;
    assign bus.tick_update     = tick_update;
    assign bus.busy            = busy;
    assign bus.locked          = locked;
    assign bus.cal_err         = cal_err;
endmodule

// File: doc/uart_autobaud_ctrl.md
UART_AUTOBAUD_CTRL -- requirements
Module: uart_autobaud_ctrl

Interface
REQ-001 CLK_FRQ, 100000000, system clock frequency in Hz; SHALL be used only for the reset-default tick count.
REQ-002 DEFAULT_BAUD, 9600, baud rate whose tick count SHALL be loaded at reset.
REQ-003 MIN_TICKS, 16, smallest legal measured tick count.
REQ-004 MAX_TICKS, 65535, largest legal measured tick count (baud_counter limit of the receiver).
REQ-005 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rx  input  1  asynchronous UART line, idle high.
REQ-008 cal_start  input  1  one-cycle pulse requesting a calibration.
REQ-009 baud_tick_count  output  32  clock cycles per bit, fed to the receiver.
REQ-010 tick_update  output  1  one-cycle pulse when baud_tick_count changes.
REQ-011 busy  output  1  high while calibrating.
REQ-012 locked  output  1  high after a successful calibration, until the next cal_start or rst.
REQ-013 cal_err  output  1  sticky error flag, cleared by cal_start or rst.

Function
REQ-014 rx SHALL pass through a 2-flop synchroniser; all edge detection SHALL use the synchronised signal.
REQ-015 Calibration character SHALL be 0x55 (8N1, LSB first), giving 5 falling edges at bit times 0,2,4,6,8.
REQ-016 FSM states SHALL be IDLE, WAIT_IDLE, WAIT_EDGE, MEASURE, DONE, ERROR.
REQ-017 IDLE: cal_start SHALL go to WAIT_IDLE, clear locked and cal_err, and set busy the next cycle.
REQ-018 WAIT_IDLE: the line SHALL be high for MAX_TICKS consecutive cycles, then go to WAIT_EDGE; any low SHALL restart the count.
REQ-019 WAIT_EDGE: the first falling edge SHALL clear the span counter and the edge counter and go to MEASURE.
REQ-020 MEASURE: the span counter SHALL increment every cycle; each falling edge SHALL increment the edge counter; the 4th edge after the first SHALL go to DONE.
REQ-021 MEASURE: the span counter reaching 8*MAX_TICKS SHALL go to ERROR (timeout).
REQ-022 DONE: result = (span + 4) >> 3 (rounded divide by 8, 32-bit unsigned); if MIN_TICKS <= result <= MAX_TICKS, load baud_tick_count, pulse tick_update, set locked, go to IDLE; otherwise go to ERROR.
REQ-023 ERROR: set cal_err, leave baud_tick_count unchanged, go to IDLE in the next cycle.
REQ-024 busy SHALL be high exactly in WAIT_IDLE, WAIT_EDGE, MEASURE and DONE.
REQ-025 cal_start while busy SHALL restart calibration at WAIT_IDLE; cal_start in the same cycle as rst SHALL be ignored.
REQ-026 baud_tick_count SHALL change only in DONE and SHALL keep its old value throughout calibration.
REQ-027 Latency: tick_update SHALL pulse 2 cycles after the synchronised 5th falling edge is sampled.

Reset
REQ-028 On rst, outputs SHALL be: baud_tick_count = CLK_FRQ/DEFAULT_BAUD (10416), tick_update 0, busy 0, locked 0, cal_err 0; the FSM SHALL be in IDLE.
REQ-029 rst mid-calibration SHALL abort the calibration with no tick_update pulse.

Configuration
REQ-030 With UART_AUTOBAUD_GLITCH_FILTER_EN defined, the synchronised rx SHALL pass through a 3-sample majority filter (+1 cycle latency); single-cycle pulses SHALL NOT count as edges.
REQ-031 Without UART_AUTOBAUD_GLITCH_FILTER_EN, no filter SHALL be present and latency SHALL be as in REQ-027.

Structure
REQ-032 State encoding, the 0x55 calibration constant, and the default CLK_FRQ/DEFAULT_BAUD SHALL live in the shared package uart_pkg.
REQ-033 Synchroniser, optional filter and falling-edge detector SHALL form one sub-module, uart_rx_edge_det.

Verification
REQ-034 rst released with no stimulus -> baud_tick_count = 10416, all flags 0.
REQ-035 cal_start, idle line, 0x55 at 868 cycles/bit -> tick_update pulse, baud_tick_count = 868, locked = 1.
REQ-036 cal_start, 0x55 at 10417 cycles/bit -> baud_tick_count = 10417, locked = 1.
REQ-037 cal_start, one falling edge, then line held low -> ERROR after 8*65535 cycles, cal_err = 1, tick count unchanged.
REQ-038 cal_start, 0x55 at 10 cycles/bit -> result 10 < MIN_TICKS, cal_err = 1, no tick_update.
REQ-039 With the macro defined, 1-cycle low glitches injected during the idle line -> no premature MEASURE; 868 cycles/bit still gives 868.
